pcie_tx_st_adapter: RTL
=======================

PCIE_TX_ST_ADAPTER -- requirements
Module: pcie_tx_st_adapter

Interface
REQ-001 SHALL have parameter READY_LATENCY, default 2: HIP TX ready-to-valid latency in cycles; legal range 1..3.
REQ-002 SHALL have parameter DEPTH, default 64: beat FIFO depth; power of 2, at least 4.
REQ-003 SHALL have port pld_clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports s_data (input, 128), s_sop (input, 1), s_eop (input, 1), s_empty (input, 1): upstream TLP beat.
REQ-006 SHALL have ports s_valid (input, 1) and s_ready (output, 1): zero-latency handshake; a beat transfers when s_valid and s_ready are both 1.
REQ-007 SHALL have ports tx_st_data (output, 128), tx_st_sop (output, 1), tx_st_eop (output, 1), tx_st_empty (output, 1) and tx_st_valid (output, 1): HIP TX stream, all registered.
REQ-008 SHALL have port tx_st_ready, input, 1: HIP TX ready, with READY_LATENCY semantics.
REQ-009 SHALL have port proto_err, output, 1: sticky upstream framing-error flag.

Function
REQ-010 SHALL push each transferred upstream beat (data, sop, eop, empty) into a DEPTH-entry FIFO in arrival order.
REQ-011 SHALL drive s_ready = 1 iff FIFO occupancy < DEPTH and rst is low.
REQ-012 SHALL keep pkt_cnt, the number of complete packets held: +1 on a push with eop, -1 on a pop with eop, unchanged when both happen in the same cycle.
REQ-013 SHALL define "permitted in cycle n" as: tx_st_ready was 1 in cycle n-READY_LATENCY, taken from a READY_LATENCY-deep ready history shift register.
REQ-014 SHALL assert tx_st_valid in cycle n only if cycle n is permitted; it never asserts otherwise.
REQ-015 SHALL implement FSM IDLE/IN_PKT, reset state IDLE.
REQ-016 IDLE: when the next cycle is permitted and pkt_cnt > 0, SHALL pop the sop beat. Pop with eop: stay in IDLE. Pop without eop: go to IN_PKT.
REQ-017 IN_PKT: SHALL pop one beat per permitted cycle and return to IDLE on the beat carrying eop.
REQ-018 SHALL gate packet start on a complete packet being held, so that inside a packet tx_st_valid drops only in non-permitted cycles.
REQ-019 SHALL take output register contents from the popped beat; in non-valid cycles tx_st_sop and tx_st_eop SHALL be 0, and data/empty hold their last value.
REQ-020 Minimum latency SHALL be 2 cycles: a single-beat packet pushed in cycle n, with permission, appears with tx_st_valid=1 in cycle n+2.
REQ-021 Full FIFO: SHALL drop s_ready. If pop and push happen in the same cycle, occupancy is unchanged.
REQ-022 Empty FIFO: SHALL never pop. Read and write pointers wrap modulo DEPTH.
REQ-023 SHALL track upstream framing with an input-side in-packet bit. proto_err SHALL set on a transferred sop while in-packet, or on a transferred non-sop beat while not in-packet. The offending beat is still stored.
REQ-024 Packets longer than DEPTH beats are illegal and SHALL be flagged by a simulation assertion.

Reset
REQ-025 While rst is high, outputs SHALL be: tx_st_valid, tx_st_sop, tx_st_eop, tx_st_empty = 0; tx_st_data = 0; s_ready = 0; proto_err = 0.
REQ-026 While rst is high, internal state SHALL be: FIFO empty, pkt_cnt = 0, ready history all 0, FSM in IDLE.
REQ-027 Reset asserted mid-packet SHALL discard all buffered beats and clear proto_err.
REQ-028 In the first cycle after rst deasserts, s_ready SHALL be 1; tx_st_valid stays 0 for at least READY_LATENCY cycles.

Verification
REQ-029 Scenario, steady single-beat packet: RL=2, tx_st_ready held 1, one beat (sop=eop=1, data=0x...AA) pushed in cycle 10 -> tx_st_valid=1 with sop=eop=1 and matching data in cycle 12 only.
REQ-030 Scenario, gated packet start: 4-beat packet pushed in cycles 0-3, ready=1 -> no tx_st_valid before cycle 5; beats go out in cycles 5-8 back-to-back, sop on the first, eop on the fourth.
REQ-031 Scenario, backpressure: RL=2, ready driven 0 in cycles 20-22 mid-packet -> tx_st_valid=0 exactly in cycles 22-24, no beat lost or duplicated.
REQ-032 Scenario, FIFO fill: DEPTH=64, ready=0, 64 beats pushed -> s_ready=0 after the 64th; raising ready drains all 64 in order, and s_ready returns to 1 one cycle after the first pop.
REQ-033 Scenario, framing error: sop pushed twice with no eop between -> proto_err=1 from the next cycle and held until rst.
REQ-034 Scenario, reset mid-packet: rst pulsed during a 3-beat packet -> all outputs 0 immediately; the next legal packet is transmitted intact.

Source files
------------

// File: rtl/pcie_tx_st_adapter.sv
// pcie_tx_st_adapter
// Buffers upstream TLP beats in a FIFO and forwards whole packets to the HIP
// TX streaming interface, respecting the HIP ready-to-valid latency.
// A packet is only started once its eop beat is buffered. Once started, the
// packet can then only pause where the HIP withdraws permission.
module pcie_tx_st_adapter #(
  parameter int READY_LATENCY = 2,
  parameter int DEPTH         = 64
) (
  input  logic         pld_clk,
  input  logic         rst,
  // upstream beat stream
  input  logic [127:0] s_data,
  input  logic         s_sop,
  input  logic         s_eop,
  input  logic         s_empty,
  input  logic         s_valid,
  output logic         s_ready,
  // HIP TX stream
  output logic [127:0] tx_st_data,
  output logic         tx_st_sop,
  output logic         tx_st_eop,
  output logic         tx_st_empty,
  output logic         tx_st_valid,
  input  logic         tx_st_ready,
  // sticky upstream framing error
  output logic         proto_err
);

  localparam int AW = $clog2(DEPTH);
  // stored beat layout: {sop, eop, empty, data[127:0]}
  localparam int BW = 131;

  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // beat storage and occupancy
  logic [BW-1:0]            mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [AW:0]              pkt_cnt_q, pkt_cnt_d;

  // HIP ready history: bit k holds tx_st_ready from k+1 cycles ago
  logic [READY_LATENCY-1:0] rdy_hist_q, rdy_hist_d;
  logic [READY_LATENCY:0]   rdy_vec_s;
  logic                     next_perm_s;
  logic                     perm_now_s;

  // transmit FSM
  state_t                   state_q, state_d;

  // input-side framing tracker
  logic                     in_pkt_q, in_pkt_d;
  logic                     proto_err_q, proto_err_d;

  // output registers
  logic [127:0]             tx_data_q, tx_data_d;
  logic                     tx_sop_q, tx_sop_d;
  logic                     tx_eop_q, tx_eop_d;
  logic                     tx_empty_q, tx_empty_d;
  logic                     tx_valid_q, tx_valid_d;

  // datapath helpers
  logic                     push_s;
  logic                     pop_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [BW-1:0]            wr_beat_s;
  logic [BW-1:0]            head_s;
  logic                     head_sop_s;
  logic                     head_eop_s;
  logic                     head_empty_s;
  logic [127:0]             head_data_s;

  // Ready is withheld while the FIFO is full and during reset.
  assign s_ready = (!fifo_full_s) && (!rst);

  // Outputs come straight from their registers.
  assign tx_st_data  = tx_data_q;
  assign tx_st_sop   = tx_sop_q;
  assign tx_st_eop   = tx_eop_q;
  assign tx_st_empty = tx_empty_q;
  assign tx_st_valid = tx_valid_q;
  assign proto_err   = proto_err_q;

  // FIFO status, handshake and head-of-queue decode.
  always_comb begin
    fifo_full_s  = (count_q == CNT_FULL);
    fifo_empty_s = (count_q == CNT_ZERO);
    push_s       = s_valid && s_ready;
    wr_beat_s    = {s_sop, s_eop, s_empty, s_data};
    head_s       = mem_q[rd_ptr_q];
    head_sop_s   = head_s[130];
    head_eop_s   = head_s[129];
    head_empty_s = head_s[128];
    head_data_s  = head_s[127:0];
  end

  // Ready history shift and permission lookup. The pop decided this cycle
  // becomes valid next cycle, so it needs ready from READY_LATENCY-1 cycles
  // ago (the live input when the latency is 1).
  always_comb begin
    rdy_vec_s   = {rdy_hist_q, tx_st_ready};
    rdy_hist_d  = rdy_vec_s[READY_LATENCY-1:0];
    next_perm_s = rdy_vec_s[READY_LATENCY-1];
    perm_now_s  = rdy_hist_q[READY_LATENCY-1];
  end

  // Transmit FSM: start only on a fully buffered packet, then one beat per
  // permitted cycle until the eop beat leaves.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (next_perm_s && (pkt_cnt_q != CNT_ZERO) && !fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_eop_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IN_PKT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IN_PKT: begin
        if (next_perm_s && !fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_eop_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_IN_PKT;
          end
        end else begin
          state_d = ST_IN_PKT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer, occupancy and complete-packet bookkeeping.
  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case ({push_s && s_eop, pop_s && head_eop_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Output register load: popped beat goes out, idle cycles clear the
  // framing flags and keep data/empty.
  always_comb begin
    if (pop_s) begin
      tx_valid_d = 1'b1;
      tx_sop_d   = head_sop_s;
      tx_eop_d   = head_eop_s;
      tx_empty_d = head_empty_s;
      tx_data_d  = head_data_s;
    end else begin
      tx_valid_d = 1'b0;
      tx_sop_d   = 1'b0;
      tx_eop_d   = 1'b0;
      tx_empty_d = tx_empty_q;
      tx_data_d  = tx_data_q;
    end
  end

  // Upstream framing check: sop is legal only outside a packet, any other
  // beat only inside one. Offending beats are still stored.
  always_comb begin
    in_pkt_d    = in_pkt_q;
    proto_err_d = proto_err_q;
    if (push_s) begin
      if (s_sop == in_pkt_q) begin
        proto_err_d = 1'b1;
      end else begin
        proto_err_d = proto_err_q;
      end
      in_pkt_d = !s_eop;
    end else begin
      in_pkt_d    = in_pkt_q;
      proto_err_d = proto_err_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge pld_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      pkt_cnt_q   <= CNT_ZERO;
      rdy_hist_q  <= {READY_LATENCY{1'b0}};
      state_q     <= ST_IDLE;
      in_pkt_q    <= 1'b0;
      proto_err_q <= 1'b0;
      tx_data_q   <= 128'h0;
      tx_sop_q    <= 1'b0;
      tx_eop_q    <= 1'b0;
      tx_empty_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_cnt_q   <= pkt_cnt_d;
      rdy_hist_q  <= rdy_hist_d;
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      proto_err_q <= proto_err_d;
      tx_data_q   <= tx_data_d;
      tx_sop_q    <= tx_sop_d;
      tx_eop_q    <= tx_eop_d;
      tx_empty_q  <= tx_empty_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  // Beat storage; contents need no reset because the pointers define validity.
  always_ff @(posedge pld_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_beat_s;
    end
  end

  // Simulation checks: a full FIFO with no eop held means an over-long
  // packet, and valid must only appear in permitted cycles.
  always @(posedge pld_clk) begin
    if (!rst) begin
      assert (!(fifo_full_s && (pkt_cnt_q == CNT_ZERO)))
        else $error("pcie_tx_st_adapter: packet longer than DEPTH beats");
      assert (!tx_valid_q || perm_now_s)
        else $error("pcie_tx_st_adapter: tx_st_valid in a non-permitted cycle");
    end
  end

endmodule
